// File: rtl/instr_feeder.sv
// Program sequencer: feeds stored instructions to the core over run/done.
// Optional watchdog abort when FEEDER_WATCHDOG_EN is defined.
module instr_feeder #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk_50MHz,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  input  logic          start,
  input  logic [AW:0]   prog_len,
  input  logic          done,
  output logic [15:0]   DIN,
  output logic          run,
  output logic          busy,
  output logic          finished,
  output logic [AW:0]   pc
`ifdef FEEDER_WATCHDOG_EN
  ,
  output logic          error
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_FIN
  } state_t;

  localparam logic [AW:0] STEP1 = (AW+1)'(1);
  localparam logic [AW:0] STEP2 = (AW+1)'(2);

  state_t      state_q, state_d;
  logic [AW:0] pc_q, pc_d;
  logic [AW:0] len_q, len_d;
  logic        mvi_q, mvi_d;
  logic        fin_q, fin_d;
`ifdef FEEDER_WATCHDOG_EN
  logic [7:0]  wdog_q, wdog_d;
  logic        err_q, err_d;
`endif

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] ra0, ra1;
  logic [15:0]   rd0, rd1;

  always_ff @(posedge clk_50MHz) begin
    if (wr_en && !busy) mem_q[wr_addr] <= wr_data;
  end

  assign ra0 = pc_q[AW-1:0];
  assign ra1 = ra0 + AW'(1);
  assign rd0 = mem_q[ra0];
  assign rd1 = mem_q[ra1];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    mvi_d   = mvi_q;
    fin_d   = fin_q;
`ifdef FEEDER_WATCHDOG_EN
    wdog_d  = wdog_q;
    err_d   = err_q;
`endif
    DIN     = '0;
    run     = 1'b0;
    busy    = 1'b0;
    unique case (state_q)
      S_IDLE, S_FIN: begin
        if (state_q == S_FIN) state_d = S_IDLE;
        if (start) begin
`ifdef FEEDER_WATCHDOG_EN
          err_d = 1'b0;
`endif
          if (prog_len == '0) begin
            state_d = S_FIN;
            fin_d   = 1'b1;
          end else begin
            len_d   = prog_len;
            pc_d    = '0;
            fin_d   = 1'b0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        DIN     = rd0;
        run     = 1'b1;
        busy    = 1'b1;
        mvi_d   = (rd0[15:13] == 3'b001);
        state_d = S_WAIT;
`ifdef FEEDER_WATCHDOG_EN
        wdog_d  = '0;
`endif
      end
      S_WAIT: begin
        busy = 1'b1;
        DIN  = mvi_q ? rd1 : rd0;
        if (done) begin
          pc_d = pc_q + (mvi_q ? STEP2 : STEP1);
          if (pc_d >= len_q) begin
            state_d = S_FIN;
            fin_d   = 1'b1;
          end else begin
            state_d = S_ISSUE;
          end
        end
`ifdef FEEDER_WATCHDOG_EN
        // Abort after 255 WAIT cycles (counter values 0..254).
        else if (wdog_q == 8'd254) begin
          state_d = S_FIN;
          fin_d   = 1'b1;
          err_d   = 1'b1;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      mvi_q   <= 1'b0;
      fin_q   <= 1'b0;
`ifdef FEEDER_WATCHDOG_EN
      wdog_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      mvi_q   <= mvi_d;
      fin_q   <= fin_d;
`ifdef FEEDER_WATCHDOG_EN
      wdog_q  <= wdog_d;
      err_q   <= err_d;
`endif
    end
  end

  assign finished = fin_q;
  assign pc       = pc_q;
`ifdef FEEDER_WATCHDOG_EN
  assign error    = err_q;
`endif

endmodule

// File: tb/tb_instr_feeder.sv
// Self-checking bench for instr_feeder; acts as loader and as the core.
// Expected behaviour comes from a program-walk model over a memory copy.
module tb_instr_feeder;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          start;
  logic [AW:0]   prog_len;
  logic          done;
  logic [15:0]   DIN;
  logic          run;
  logic          busy;
  logic          finished;
  logic [AW:0]   pc;
`ifdef FEEDER_WATCHDOG_EN
  logic          error;
`endif

  int tests = 0;
  int fails = 0;
  logic [15:0] mm [DEPTH];
  int run_cnt = 0;
  int dbl = 0;
  logic prev_run = 1'b0;

  instr_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_50MHz(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .start(start),
    .prog_len(prog_len),
    .done(done),
    .DIN(DIN),
    .run(run),
    .busy(busy),
    .finished(finished),
    .pc(pc)
`ifdef FEEDER_WATCHDOG_EN
    ,
    .error(error)
`endif
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    prev_run <= run;
    if (run) run_cnt <= run_cnt + 1;
    if (run && prev_run) dbl <= dbl + 1;
  end

  task automatic load(input int a, input logic [15:0] d);
    wr_en = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    mm[a] = d;
  endtask

  function automatic logic [15:0] rand_word(input bit allow_mvi);
    logic [15:0] w;
    w = 16'($urandom);
    if (allow_mvi && $urandom_range(0, 2) == 0) w[15:13] = 3'b001;
    else if (w[15:13] == 3'b001) w[15:13] = 3'b011;
    return w;
  endfunction

  task automatic exec(input int len, input bit wr, input int wa,
                      input logic [15:0] wd, input int lmin, input int lmax);
    logic [15:0] iss[$];
    logic [15:0] imm[$];
    int pcs[$];
    int p;
    int lat;
    int r0;
    logic [15:0] w;
    if (wr) mm[wa] = wd;
    p = 0;
    while (p < len) begin
      w = mm[p];
      iss.push_back(w);
      if (w[15:13] == 3'b001) begin
        imm.push_back(mm[(p + 1) % DEPTH]);
        p += 2;
      end else begin
        imm.push_back(w);
        p += 1;
      end
      pcs.push_back(p);
    end
    r0 = run_cnt;
    start = 1'b1;
    prog_len = (AW+1)'(len);
    if (wr) begin
      wr_en = 1'b1;
      wr_addr = AW'(wa);
      wr_data = wd;
    end
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    if (iss.size() == 0) begin
      tests++;
      if (finished !== 1'b1 || run !== 1'b0 || busy !== 1'b0) begin
        $display("FAIL len0_finish fin=%b run=%b busy=%b expected 1 0 0",
                 finished, run, busy);
        fails++;
      end
    end
    foreach (iss[i]) begin
      tests++;
      if (run !== 1'b1 || DIN !== iss[i]) begin
        $display("FAIL issue[%0d] run=%b DIN=%h expected run=1 DIN=%h",
                 i, run, DIN, iss[i]);
        fails++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      done = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat = $urandom_range(lmin, lmax);
      for (int c = 0; c <= lat; c++) begin
        tests++;
        if (run !== 1'b0 || busy !== 1'b1 || DIN !== imm[i]) begin
          $display("FAIL wait[%0d] run=%b busy=%b DIN=%h expected 0 1 %h",
                   i, run, busy, DIN, imm[i]);
          fails++;
        end
        done = (c == lat);
        @(negedge clk);
      end
      done = 1'b0;
      tests++;
      if (pc !== (AW+1)'(pcs[i])) begin
        $display("FAIL pc[%0d] got=%0d expected=%0d", i, pc, pcs[i]);
        fails++;
      end
      if (i == iss.size() - 1) begin
        tests++;
        if (finished !== 1'b1 || busy !== 1'b0 || run !== 1'b0) begin
          $display("FAIL fin_entry fin=%b busy=%b run=%b expected 1 0 0",
                   finished, busy, run);
          fails++;
        end
      end
    end
    @(negedge clk);
    tests++;
    if (finished !== 1'b1 || busy !== 1'b0 ||
        run_cnt - r0 != iss.size()) begin
      $display("FAIL idle_after fin=%b busy=%b runs=%0d expected 1 0 %0d",
               finished, busy, run_cnt - r0, iss.size());
      fails++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    wr_en = 1'b0;
    start = 1'b0;
    done = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    prog_len = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (DIN !== 16'h0 || run !== 1'b0 || busy !== 1'b0 ||
        finished !== 1'b0 || pc !== '0) begin
      $display("FAIL reset_state DIN=%h run=%b busy=%b fin=%b pc=%0d expected all 0",
               DIN, run, busy, finished, pc);
      fails++;
    end
    load(0, 16'h4000);
    load(1, 16'h6000);
    start = 1'b1;
    prog_len = 6'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    tests++;
    if (pc !== 6'd1 || busy !== 1'b1) begin
      $display("FAIL pre_reset pc=%0d busy=%b expected 1 1", pc, busy);
      fails++;
    end
    #3 reset = 1'b1;
    #1;
    tests++;
    if (DIN !== 16'h0 || run !== 1'b0 || busy !== 1'b0 ||
        finished !== 1'b0 || pc !== '0) begin
      $display("FAIL async_reset DIN=%h run=%b busy=%b fin=%b pc=%0d expected all 0",
               DIN, run, busy, finished, pc);
      fails++;
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || run !== 1'b0) begin
      $display("FAIL post_reset busy=%b run=%b expected 0 0", busy, run);
      fails++;
    end
  endtask

  task automatic test_three_word;
    load(0, 16'h0000);
    load(1, 16'h4000);
    load(2, 16'h6000);
    exec(3, 1'b0, 0, 16'h0, 2, 2);
  endtask

  task automatic test_mvi;
    load(0, 16'h2000);
    load(1, 16'h00AB);
    exec(2, 1'b0, 0, 16'h0, 1, 4);
  endtask

  task automatic test_len_zero;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exec(0, 1'b0, 0, 16'h0, 0, 0);
  endtask

  task automatic test_wr_busy;
    load(0, 16'h4000);
    start = 1'b1;
    prog_len = 6'd1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = '0;
    wr_data = 16'h6000;
    start = 1'b1;
    prog_len = 6'd5;
    @(negedge clk);
    wr_en = 1'b0;
    start = 1'b0;
    tests++;
    if (busy !== 1'b1 || DIN !== 16'h4000) begin
      $display("FAIL busy_write busy=%b DIN=%h expected 1 4000", busy, DIN);
      fails++;
    end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    tests++;
    if (pc !== 6'd1 || finished !== 1'b1) begin
      $display("FAIL busy_start pc=%0d fin=%b expected 1 1", pc, finished);
      fails++;
    end
    @(negedge clk);
    exec(1, 1'b0, 0, 16'h0, 0, 1);
  endtask

  task automatic test_wr_start_same;
    exec(1, 1'b1, 0, 16'h5A5A, 0, 2);
    load(1, 16'h1234);
    exec(2, 1'b1, 0, 16'h2BCD, 0, 2);
  endtask

  task automatic test_idle_done;
    int r0;
    logic [AW:0] pcv;
    r0 = run_cnt;
    pcv = pc;
    done = 1'b1;
    repeat (3) @(negedge clk);
    done = 1'b0;
    tests++;
    if (run_cnt != r0 || busy !== 1'b0 || pc !== pcv) begin
      $display("FAIL idle_done runs=%0d busy=%b pc=%0d expected %0d 0 %0d",
               run_cnt, busy, pc, r0, pcv);
      fails++;
    end
  endtask

  task automatic test_wrap;
    for (int a = 0; a < DEPTH - 1; a++) load(a, rand_word(1'b0));
    load(DEPTH - 1, {3'b001, 13'($urandom)});
    exec(DEPTH, 1'b0, 0, 16'h0, 0, 1);
    tests++;
    if (pc !== 6'd33) begin
      $display("FAIL wrap_pc got=%0d expected=33", pc);
      fails++;
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 8; it++) begin
      for (int a = 0; a < DEPTH; a++) load(a, rand_word(1'b1));
      exec($urandom_range(0, DEPTH), 1'b0, 0, 16'h0, 0, 3);
    end
  endtask

  task automatic test_back_to_back;
    for (int a = 0; a < DEPTH; a++) load(a, rand_word(1'b1));
    for (int it = 0; it < 4; it++)
      exec($urandom_range(1, 8), 1'b0, 0, 16'h0, 0, 0);
    tests++;
    if (dbl != 0) begin
      $display("FAIL double_run got=%0d expected=0", dbl);
      fails++;
    end
  endtask

`ifdef FEEDER_WATCHDOG_EN
  task automatic test_watchdog;
    int cyc;
    load(0, 16'h4000);
    start = 1'b1;
    prog_len = 6'd1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (finished !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    tests++;
    if (cyc != 256 || error !== 1'b1 || pc !== '0) begin
      $display("FAIL watchdog cyc=%0d err=%b pc=%0d expected 256 1 0",
               cyc, error, pc);
      fails++;
    end
    @(negedge clk);
    exec(1, 1'b0, 0, 16'h0, 0, 1);
    tests++;
    if (error !== 1'b0) begin
      $display("FAIL wd_clear err=%b expected 0", error);
      fails++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_three_word();
    test_mvi();
    test_len_zero();
    test_idle_done();
    test_wr_busy();
    test_wr_start_same();
    test_wrap();
    test_random();
    test_back_to_back();
`ifdef FEEDER_WATCHDOG_EN
    test_watchdog();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_feeder.md
# instr_feeder

Program sequencer that drives the processor's instruction port from the other side of its `run`/`done` handshake. It holds a small preloaded program memory and presents one instruction word on `DIN`. For move-immediate instructions it also presents the immediate word. It pulses `run`, waits for `done`, then advances its program counter until the program length is exhausted. It sits between a host/loader port and the processor core, in the same 50 MHz domain.

## Interface
- `DEPTH`, 32, program memory words; power of two, minimum 4.
- `AW`, 5, address width; equals log2(`DEPTH`).
- `clk_50MHz`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  program-memory write strobe; honoured only when not busy.
- `wr_addr`  in  AW  program-memory write address.
- `wr_data`  in  16  program-memory write data.
- `start`  in  1  begin executing from address 0; honoured only when not busy.
- `prog_len`  in  AW+1  number of words to execute (0..`DEPTH`); sampled on `start`.
- `done`  in  1  processor completion strobe.
- `DIN`  out  16  instruction/immediate word to the processor.
- `run`  out  1  one-cycle instruction-issue pulse.
- `busy`  out  1  high from the accepted `start` until entry to FIN or IDLE.
- `finished`  out  1  level; program completed; cleared by the next accepted `start`.
- `pc`  out  AW+1  current program counter.
- `error`  out  1  watchdog abort flag; present only with `FEEDER_WATCHDOG_EN`.

Decided: one clock; reset is asynchronous and active-high.

## Operation
- **Opcode and mvi:** opcode is `DIN[15:13]`. `3'b001` = mvi, a two-word instruction. All other opcodes are one word.
- **Program memory:** `DEPTH`×16, synchronous write.
  - Combinational read at `pc[AW-1:0]` and `pc[AW-1:0]+1`.
  - The +1 read address wraps modulo `DEPTH`.
  - Contents are not affected by reset.
- **IDLE:**
  - `busy`=0.
  - `start` with `prog_len`=0 goes to FIN.
  - `start` with `prog_len`>0 latches `prog_len`, sets `pc`=0, clears `finished`, and goes to ISSUE.
- **ISSUE:**
  - `DIN`=mem[pc], `run`=1 for exactly this cycle.
  - Latch `is_mvi` from the opcode, then go to WAIT.
  - `done` is ignored in this state.
- **WAIT:**
  - `run`=0.
  - `DIN` = mem[pc+1] if `is_mvi`, otherwise mem[pc]. It is held stable until `done`.
  - On `done`: `pc` ← pc+2 if `is_mvi`, else pc+1.
  - If the new `pc` ≥ latched length, go to FIN; otherwise go to ISSUE.
- **FIN:**
  - `finished`=1 and `busy`=0; go to IDLE next cycle.
  - `finished` stays 1 in IDLE.
- **Boundary cases:**
  - mvi as the last word still fetches mem[pc+1], with the address wrapped.
  - `pc` may then exceed the length by 1; this is treated as complete.
  - `wr_en` or `start` while busy is ignored; memory and length are unchanged.
  - `wr_en` and `start` in the same idle cycle: the write commits, and execution reads the new value.
  - A `done` while IDLE or FIN is ignored.
- **Reset mid-program:** returns to IDLE immediately. `run`, `busy`, `finished`, `error` → 0; `pc` → 0; `DIN` → 0.

## Timing
- Reset values: `DIN`=0, `run`=0, `busy`=0, `finished`=0, `pc`=0, `error`=0, state IDLE.
- Accepted `start` at edge k: `run` is high in cycle k+1.
- `done` sampled at edge m: the next `run` is high in cycle m+1, or `finished` is high from cycle m+1.
- `DIN` switches to the immediate word in the cycle after `run`; the processor samples it no earlier.
- `run` is never high in two consecutive cycles.
- Minimum per-instruction period: 2 cycles plus processor latency.

## Configuration
- **`FEEDER_WATCHDOG_EN` defined:**
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches 255 without `done`: go to FIN with `error`=1 and `finished`=1; `pc` is not advanced.
  - `error` clears on the next accepted `start`.
- **`FEEDER_WATCHDOG_EN` undefined:** no counter; `error` port absent; WAIT waits indefinitely.

## Test plan
- **Reset:** assert `reset` mid-WAIT → all outputs 0 and state IDLE within the same cycle, asynchronously.
- **Three-word program:** load 0x0000, 0x4000, 0x6000; `prog_len`=3; `start`; answer `done` 3 cycles after each `run`.
  - Required: three `run` pulses with `DIN`=0x0000, 0x4000, 0x6000; `pc` steps 1, 2, 3; `finished`=1.
- **mvi:** load 0x2000, 0x00AB, `prog_len`=2.
  - Required: `run` with `DIN`=0x2000, then `DIN`=0x00AB held until `done`; `pc`=2; one `run` only.
- **Edge cases:**
  - `prog_len`=0 → `finished`=1 one cycle after `start`, no `run`.
  - `wr_en` while busy → memory unchanged on readback.
- **Wrap:** `DEPTH`=32, mvi at address 31, `prog_len`=32 → immediate taken from mem[0]; `pc`=33; `finished`.
- **Watchdog (with `FEEDER_WATCHDOG_EN`):** never assert `done` → `error`=1 and `finished`=1 after 255 WAIT cycles; the next `start` clears `error`.
